freq_meas_sequencer: RTL

Measurement scheduler for low_freq_counter. It issues the one-cycle start pulse and tracks the measured signal's rising edges to decide when a period measurement has completed. After a settle window for the counter's divide and BCD conversion, it latches the 4-digit BCD result into a stable display register. It re-triggers periodically while enabled and reports a no-signal condition on timeout.

---
 rtl/freq_meas_sequencer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/freq_meas_sequencer.sv
// Measurement scheduler for low_freq_counter: issues start pulses, watches two
// synchronized rising edges, waits for the result to settle, then latches it for display.
module freq_meas_sequencer #(
    parameter int SETTLE_CYCLES  = 256,
    parameter int TIMEOUT_CYCLES = 200_000_000,
    parameter int HOLDOFF_CYCLES = 50_000_000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic       i_signal,
    input  logic [3:0] i_freq_bcd [3:0],
    output logic       o_start,
    output logic [3:0] o_disp_bcd [3:0],
    output logic       o_valid,
    output logic       o_no_signal,
    output logic       o_busy
);

    localparam int MAX_AB     = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
    localparam int MAX_CYCLES = (MAX_AB > HOLDOFF_CYCLES) ? MAX_AB : HOLDOFF_CYCLES;
    localparam int TW         = $clog2(MAX_CYCLES + 1);

    localparam logic [TW-1:0] SETTLE_LAST  = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] HOLDOFF_LAST = TW'(HOLDOFF_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_E1,
        WAIT_E2,
        SETTLE,
        LATCH,
        TOUT,
        HOLDOFF
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          prev_q, prev_d;
    logic          start_q, start_d;
    logic          valid_q, valid_d;
    logic          no_signal_q, no_signal_d;
    logic          busy_q, busy_d;
    logic          rise;

    assign rise = sync2_q & ~prev_q;

    always_comb begin
        sync1_d = i_signal;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        state_d = state_q;

        case (state_q)
            IDLE:    if (i_en) state_d = START;
            START:   state_d = WAIT_E1;
            WAIT_E1: begin
                // A rise on the terminal count still counts as an edge.
                if (rise)                         state_d = WAIT_E2;
                else if (timer_q == TIMEOUT_LAST) state_d = TOUT;
            end
            WAIT_E2: begin
                if (rise)                         state_d = SETTLE;
                else if (timer_q == TIMEOUT_LAST) state_d = TOUT;
            end
            SETTLE:  if (timer_q == SETTLE_LAST) state_d = LATCH;
            LATCH:   state_d = HOLDOFF;
            TOUT:    state_d = HOLDOFF;
            HOLDOFF: if (timer_q == HOLDOFF_LAST) state_d = i_en ? START : IDLE;
            default: state_d = IDLE;
        endcase

        timer_d = timer_q + TW'(1);
        if (state_d != state_q || state_q == IDLE) timer_d = '0;

        // Outputs are registered from the next state so they line up with the state itself.
        start_d     = (state_d == START);
        valid_d     = (state_d == LATCH) || (state_d == TOUT);
        busy_d      = (state_d != IDLE);
        no_signal_d = no_signal_q;
        if (state_d == LATCH)     no_signal_d = 1'b0;
        else if (state_d == TOUT) no_signal_d = 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            prev_q      <= 1'b0;
            start_q     <= 1'b0;
            valid_q     <= 1'b0;
            no_signal_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            prev_q      <= prev_d;
            start_q     <= start_d;
            valid_q     <= valid_d;
            no_signal_q <= no_signal_d;
            busy_q      <= busy_d;
        end
    end

    // Digits are captured on entry to LATCH so the new value appears together with o_valid.
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
        logic [3:0] digit_q, digit_d;

        always_comb begin
            digit_d = digit_q;
            if (state_d == LATCH)     digit_d = i_freq_bcd[gi];
            else if (state_d == TOUT) digit_d = '0;
        end

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) digit_q <= '0;
            else       digit_q <= digit_d;
        end

        assign o_disp_bcd[gi] = digit_q;
    end

    assign o_start     = start_q;
    assign o_valid     = valid_q;
    assign o_no_signal = no_signal_q;
    assign o_busy      = busy_q;

endmodule
